// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM encoding, base address.
package intr_ctrl_pkg;

   localparam logic [1:0] INTC_MASK = 2'd0;
   localparam logic [1:0] INTC_PEND = 2'd1;
   localparam logic [1:0] INTC_ACT  = 2'd2;
   localparam logic [1:0] INTC_CTRL = 2'd3;

   localparam logic [31:0] INTC_ADDR_BASE = 32'h0000_7F20;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } intc_state_e;

endpackage

// File: rtl/intr_ctrl_if.sv
// Bridge register access plus CPU request/acknowledge/return handshake of the interrupt controller.
interface intr_ctrl_if;

   logic [31:0] bus_addr;
   logic        bus_we;
   logic [31:0] bus_wd;
   logic [31:0] bus_rd;
   logic        irq_req;
   logic [2:0]  irq_id;
   logic        irq_ack;
   logic        eret;

   modport master (
      output bus_addr, bus_we, bus_wd, irq_ack, eret,
      input  bus_rd, irq_req, irq_id
   );

   modport slave (
      input  bus_addr, bus_we, bus_wd, irq_ack, eret,
      output bus_rd, irq_req, irq_id
   );

endinterface

// File: rtl/intr_prio_enc.sv
// Combinational lowest-index-wins priority encoder producing {valid, id}.
module intr_prio_enc #(
   parameter int unsigned NUM_SRC = 2
) (
   input  logic [NUM_SRC-1:0] req,
   output logic               valid,
   output logic [2:0]         id
);

   always_comb begin
      valid = 1'b0;
      id    = 3'd0;
      // Scan from the top down so the lowest set index is the last one written.
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            id    = 3'(i);
         end
      end
   end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: pending capture, mask/GIE gating, priority pick and CPU handshake FSM.
// Define INTC_LEVEL_EN for level-sensitive sources (PENDING mirrors src, no W1C, no ack clear).
module intr_ctrl
   import intr_ctrl_pkg::*;
#(
   parameter int unsigned NUM_SRC   = 2,
   parameter logic [31:0] ADDR_BASE = INTC_ADDR_BASE
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] src,
   intr_ctrl_if.slave         intc
);

   intc_state_e        state_q;
   logic [NUM_SRC-1:0] mask_q;
   logic [NUM_SRC-1:0] pend_q;
   logic [NUM_SRC-1:0] pend_d;
   logic               gie_q;
   logic               act_valid_q;
   logic [2:0]         act_id_q;
   logic               irq_req_q;
   logic [2:0]         irq_id_q;

   logic [NUM_SRC-1:0] elig;
   logic               win_valid;
   logic [2:0]         win_id;
   logic               hit;
   logic               wr;
   logic [1:0]         idx;
   logic               ack_take;
   logic               unused;

   assign idx      = intc.bus_addr[3:2];
   assign hit      = (intc.bus_addr[31:4] == ADDR_BASE[31:4]);
   assign wr       = intc.bus_we && hit;
   assign elig     = pend_q & mask_q & {NUM_SRC{gie_q}};
   assign ack_take = (state_q == REQ) && intc.irq_ack && win_valid;
   assign unused   = ^{intc.bus_addr[1:0], intc.bus_wd};

   intr_prio_enc #(
      .NUM_SRC (NUM_SRC)
   ) u_prio (
      .req   (elig),
      .valid (win_valid),
      .id    (win_id)
   );

`ifdef INTC_LEVEL_EN
   assign pend_d = src;
`else
   logic [NUM_SRC-1:0] src_q;
   logic [NUM_SRC-1:0] win_onehot;

   assign win_onehot = NUM_SRC'(1) << win_id;

   always_comb begin
      pend_d = pend_q;
      if (wr && idx == INTC_PEND) pend_d = pend_d & ~intc.bus_wd[NUM_SRC-1:0];
      if (ack_take) pend_d = pend_d & ~win_onehot;
      // A fresh rising edge applied last so it beats a same-cycle clear.
      pend_d = pend_d | (src & ~src_q);
   end

   always_ff @(posedge clk) begin
      if (!reset) src_q <= '0;
      else        src_q <= src;
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         mask_q      <= '0;
         pend_q      <= '0;
         gie_q       <= 1'b0;
         act_valid_q <= 1'b0;
         act_id_q    <= 3'd0;
         irq_req_q   <= 1'b0;
         irq_id_q    <= 3'd0;
      end else begin
         pend_q <= pend_d;
         if (wr && idx == INTC_MASK) mask_q <= intc.bus_wd[NUM_SRC-1:0];
         if (wr && idx == INTC_CTRL) gie_q <= intc.bus_wd[0];

         case (state_q)
            IDLE: begin
               irq_req_q <= 1'b0;
               if (win_valid) begin
                  state_q   <= REQ;
                  irq_req_q <= 1'b1;
                  irq_id_q  <= win_id;
               end
            end
            REQ: begin
               if (!win_valid) begin
                  state_q   <= IDLE;
                  irq_req_q <= 1'b0;
               end else if (intc.irq_ack) begin
                  state_q     <= SERVICE;
                  irq_req_q   <= 1'b0;
                  irq_id_q    <= win_id;
                  act_valid_q <= 1'b1;
                  act_id_q    <= win_id;
               end else begin
                  irq_id_q <= win_id;
               end
            end
            SERVICE: begin
               irq_req_q <= 1'b0;
               if (intc.eret) begin
                  state_q     <= IDLE;
                  act_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               irq_req_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      intc.bus_rd = 32'd0;
      if (hit) begin
         case (idx)
            INTC_MASK: intc.bus_rd = 32'(mask_q);
            INTC_PEND: intc.bus_rd = 32'(pend_q);
            INTC_ACT:  intc.bus_rd = 32'({act_valid_q, act_id_q});
            default:   intc.bus_rd = 32'(gie_q);
         endcase
      end
   end

   assign intc.irq_req = irq_req_q;
   assign intc.irq_id  = irq_id_q;

endmodule
